// File: rtl/vga_game_timing_pkg.sv
// Raster and game-field constants shared by the vga_game_timing display path:
// 800x600 VGA timing and the Pac-Man 224x288 field upscaled by two.
package vga_game_timing_pkg;

    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 40;
    localparam int VGA_H_SYNC    = 128;
    localparam int VGA_H_BACK    = 88;
    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 1;
    localparam int VGA_V_SYNC    = 4;
    localparam int VGA_V_BACK    = 23;
    localparam bit VGA_SYNC_POL  = 1'b1;

    localparam int PACMAN_H_VISIBLE_AREA = 224;
    localparam int PACMAN_V_VISIBLE_AREA = 288;
    localparam int PACMAN_SCALE          = 2;

    // Left/top margin that centres the scaled game field in the visible area.
    function automatic int win_offset(input int visible, input int game, input int scale);
        return (visible - game * scale) / 2;
    endfunction

    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_game_timing_axis_counter.sv
// One raster axis: physical position counter plus the game-space sub-pixel
// and coordinate counters that restart at the window's leading edge.
module game_axis_counter
    import vga_game_timing_pkg::*;
#(
    parameter int TOTAL     = 1056,
    parameter int OFFSET    = 176,
    parameter int SCALE     = 2,
    parameter int GAME_SIZE = 224,
    localparam int CW = $clog2(TOTAL),
    localparam int SW = bits_for(SCALE),
    localparam int GW = $clog2(GAME_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          lower_wrap,
    output logic [CW-1:0] count,
    output logic          in_win,
    output logic [SW-1:0] sub,
    output logic [GW-1:0] game
);

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] WIN_LO   = CW'(OFFSET);
    localparam logic [CW-1:0] WIN_HI   = CW'(OFFSET + GAME_SIZE * SCALE);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [GW-1:0] game_q, game_d;
    logic          step;

    assign step   = en & lower_wrap;
    assign in_win = (count_q >= WIN_LO) && (count_q < WIN_HI);

    // Sub/game values always describe the position held in count_q, so they
    // are loaded together with the position that enters the window.
    always_comb begin
        count_d = count_q;
        sub_d   = sub_q;
        game_d  = game_q;
        if (step) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
            if (count_d == WIN_LO) begin
                sub_d  = '0;
                game_d = '0;
            end else if (in_win) begin
                if (sub_q == SUB_LAST) begin
                    sub_d  = '0;
                    game_d = game_q + 1'b1;
                end else begin
                    sub_d = sub_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sub_q   <= '0;
            game_q  <= '0;
        end else begin
            count_q <= count_d;
            sub_q   <= sub_d;
            game_q  <= game_d;
        end
    end

    assign count = count_q;
    assign sub   = sub_q;
    assign game  = game_q;

endmodule

// File: rtl/vga_game_timing.sv
// VGA sync plus upscaled game-space strobes/coordinates for the Pac-Man path.
// GAME_PIX_STB_ALL_LINES_EN: game_pix_stb fires on every physical line of a game row.
module vga_game_timing
    import vga_game_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_POL  = VGA_SYNC_POL,
    parameter int SCALE     = PACMAN_SCALE,
    parameter int GAME_W    = PACMAN_H_VISIBLE_AREA,
    parameter int GAME_H    = PACMAN_V_VISIBLE_AREA
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      hsync,
    output logic                      vsync,
    output logic [$clog2(GAME_W)-1:0] sx,
    output logic [$clog2(GAME_H)-1:0] sy,
    output logic                      game_pix_stb,
    output logic                      frame_stb,
    output logic                      display_enabled
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HCW = $clog2(H_TOTAL);
    localparam int VCW = $clog2(V_TOTAL);
    localparam int SW  = bits_for(SCALE);
    localparam int XW  = $clog2(GAME_W);
    localparam int YW  = $clog2(GAME_H);

    localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] HS_LO   = HCW'(H_VISIBLE + H_FRONT);
    localparam logic [HCW-1:0] HS_HI   = HCW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] VS_LO   = VCW'(V_VISIBLE + V_FRONT);
    localparam logic [VCW-1:0] VS_HI   = VCW'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef GAME_PIX_STB_ALL_LINES_EN
    localparam bit PIX_ALL_LINES = 1'b1;
`else
    localparam bit PIX_ALL_LINES = 1'b0;
`endif

    logic [HCW-1:0] hc;
    logic [VCW-1:0] vc;
    logic [SW-1:0]  hsub, vsub;
    logic [XW-1:0]  hx;
    logic [YW-1:0]  vy;
    logic           h_in, v_in, in_win, h_wrap;

    assign h_wrap = (hc == H_LAST);
    assign in_win = h_in & v_in;

    game_axis_counter #(
        .TOTAL(H_TOTAL), .OFFSET(win_offset(H_VISIBLE, GAME_W, SCALE)),
        .SCALE(SCALE), .GAME_SIZE(GAME_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .en(1'b1), .lower_wrap(1'b1),
        .count(hc), .in_win(h_in), .sub(hsub), .game(hx)
    );

    game_axis_counter #(
        .TOTAL(V_TOTAL), .OFFSET(win_offset(V_VISIBLE, GAME_H, SCALE)),
        .SCALE(SCALE), .GAME_SIZE(GAME_H)
    ) u_v_axis (
        .clk(clk), .rst(rst), .en(1'b1), .lower_wrap(h_wrap),
        .count(vc), .in_win(v_in), .sub(vsub), .game(vy)
    );

    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic          pix_q, pix_d, frame_q, frame_d, de_q, de_d;

    always_comb begin
        hsync_d = ((hc >= HS_LO) && (hc < HS_HI)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vc >= VS_LO) && (vc < VS_HI)) ? SYNC_POL : ~SYNC_POL;
        de_d    = in_win;
        sx_d    = in_win ? hx : '0;
        sy_d    = in_win ? vy : '0;
        pix_d   = in_win && (hsub == '0) && (PIX_ALL_LINES || (vsub == '0));
        frame_d = in_win && (hsub == '0) && (vsub == '0) && (hx == '0) && (vy == '0);
    end

    // Every output goes through one register stage so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            sx_q    <= '0;
            sy_q    <= '0;
            pix_q   <= 1'b0;
            frame_q <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            pix_q   <= pix_d;
            frame_q <= frame_d;
            de_q    <= de_d;
        end
    end

    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign sx              = sx_q;
    assign sy              = sy_q;
    assign game_pix_stb    = pix_q;
    assign frame_stb       = frame_q;
    assign display_enabled = de_q;

endmodule

// File: tb/tb_vga_game_timing.sv
// Scoreboard bench for vga_game_timing: full-size, reduced SCALE=2 (inverted
// sync polarity) and reduced SCALE=1 instances against an arithmetic raster model.
module tb_vga_game_timing;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb, gw, gh, s;
        bit pol;
    } cfg_t;

    typedef struct packed {
        logic        hs, vs;
        logic [15:0] sx, sy;
        logic        pix, frm, de;
    } obs_t;

    typedef struct packed {
        obs_t a, b, c;
    } exp_t;

`ifdef GAME_PIX_STB_ALL_LINES_EN
    localparam bit ALL_LINES = 1'b1;
`else
    localparam bit ALL_LINES = 1'b0;
`endif

    localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
    localparam int SVV = 40, SVF = 1, SVS = 2, SVB = 3;
    localparam int SGW = 20, SGH = 16;
    localparam int B_FRAME   = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);
    localparam int B_PIX_EXP = ALL_LINES ? SGW * SGH * 2 : SGW * SGH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_pix, a_frm, a_de;
    logic [7:0] a_sx;
    logic [8:0] a_sy;
    logic       b_hs, b_vs, b_pix, b_frm, b_de;
    logic [4:0] b_sx;
    logic [3:0] b_sy;
    logic       c_hs, c_vs, c_pix, c_frm, c_de;
    logic [4:0] c_sx;
    logic [3:0] c_sy;

    vga_game_timing dut_a (
        .clk(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .sx(a_sx), .sy(a_sy),
        .game_pix_stb(a_pix), .frame_stb(a_frm), .display_enabled(a_de)
    );

    vga_game_timing #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_POL(1'b0), .SCALE(2), .GAME_W(SGW), .GAME_H(SGH)
    ) dut_b (
        .clk(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs), .sx(b_sx), .sy(b_sy),
        .game_pix_stb(b_pix), .frame_stb(b_frm), .display_enabled(b_de)
    );

    vga_game_timing #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_POL(1'b1), .SCALE(1), .GAME_W(SGW), .GAME_H(SGH)
    ) dut_c (
        .clk(clk), .rst(rst), .hsync(c_hs), .vsync(c_vs), .sx(c_sx), .sy(c_sy),
        .game_pix_stb(c_pix), .frame_stb(c_frm), .display_enabled(c_de)
    );

    cfg_t ca, cb, cc;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edges  = 0;
    bit   running = 1'b0;

    // Clock edges seen since reset release; edge k shows the raster position k-1.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic obs_t reset_obs(input bit pol);
        obs_t o;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        return o;
    endfunction

    function automatic obs_t model(input cfg_t c, input int n);
        obs_t o;
        int ht, vt, pos, hc, vc, dx, dy, ho, vo;
        ht  = c.hv + c.hf + c.hs + c.hb;
        vt  = c.vv + c.vf + c.vs + c.vb;
        pos = n % (ht * vt);
        hc  = pos % ht;
        vc  = pos / ht;
        ho  = (c.hv - c.gw * c.s) / 2;
        vo  = (c.vv - c.gh * c.s) / 2;
        dx  = hc - ho;
        dy  = vc - vo;
        o = '0;
        o.hs = (hc >= c.hv + c.hf && hc < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
        o.vs = (vc >= c.vv + c.vf && vc < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
        o.de = (dx >= 0 && dx < c.gw * c.s && dy >= 0 && dy < c.gh * c.s);
        if (o.de) begin
            o.sx  = 16'(dx / c.s);
            o.sy  = 16'(dy / c.s);
            o.pix = (dx % c.s == 0) && (ALL_LINES || (dy % c.s == 0));
            o.frm = (dx == 0) && (dy == 0);
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic check_obs(input string nm, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s @%0t edge=%0d: got hs=%b vs=%b sx=%0d sy=%0d pix=%b frm=%b de=%b expected hs=%b vs=%b sx=%0d sy=%0d pix=%b frm=%b de=%b",
                     nm, $time, edges, g.hs, g.vs, g.sx, g.sy, g.pix, g.frm, g.de,
                     e.hs, e.vs, e.sx, e.sy, e.pix, e.frm, e.de);
        end
    endtask

    // Producer: expected outputs for this cycle go into the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst || edges == 0) begin
            e.a = reset_obs(ca.pol);
            e.b = reset_obs(cb.pol);
            e.c = reset_obs(cc.pol);
        end else begin
            e.a = model(ca, edges - 1);
            e.b = model(cb, edges - 1);
            e.c = model(cc, edges - 1);
        end
        if (running) sb.push_back(e);
    end

    bit a_seen = 1'b0;
    int b_last = -1, b_pix_cnt = 0, b_symax = 0;
    bit c_de_prev = 1'b0;
    int c_sx_prev = 0;

    // Monitor: pops the expectation and compares against sampled DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (running) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty @%0t", $time);
            end else begin
                e = sb.pop_front();
                check_obs("dut_a", {a_hs, a_vs, 16'(a_sx), 16'(a_sy), a_pix, a_frm, a_de}, e.a);
                check_obs("dut_b", {b_hs, b_vs, 16'(b_sx), 16'(b_sy), b_pix, b_frm, b_de}, e.b);
                check_obs("dut_c", {c_hs, c_vs, 16'(c_sx), 16'(c_sy), c_pix, c_frm, c_de}, e.c);
            end
            if (rst) begin
                a_seen    = 1'b0;
                b_last    = -1;
                b_pix_cnt = 0;
                b_symax   = 0;
                c_de_prev = 1'b0;
            end else begin
                if (a_frm && !a_seen) begin
                    a_seen = 1'b1;
                    chk("a_first_frame_cycle", edges, 12849);
                    chk("a_first_frame_sx_sy_de", {a_sx, a_sy, a_de}, 1);
                end
                if (b_frm) begin
                    if (b_last >= 0) begin
                        chk("b_frame_period", edges - b_last, B_FRAME);
                        chk("b_pix_per_frame", b_pix_cnt, B_PIX_EXP);
                        chk("b_sy_max", b_symax, SGH - 1);
                    end
                    b_last    = edges;
                    b_pix_cnt = 0;
                    b_symax   = 0;
                end
                if (b_pix) b_pix_cnt++;
                if (int'(b_sy) > b_symax) b_symax = int'(b_sy);
                chk("c_pix_eq_de", int'(c_pix), int'(c_de));
                if (c_de && c_de_prev) chk("c_sx_step", int'(c_sx), c_sx_prev + 1);
                c_de_prev = c_de;
                c_sx_prev = int'(c_sx);
            end
        end
    end

    initial begin
        ca = '{800, 40, 128, 88, 600, 1, 4, 23, 224, 288, 2, 1'b1};
        cb = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SGW, SGH, 2, 1'b0};
        cc = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SGW, SGH, 1, 1'b1};
        #1 rst = 1'b1;
        running = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (13000) @(posedge clk);
        chk("a_first_frame_seen", int'(a_seen), 1);
        repeat (4) begin
            repeat ($urandom_range(300, 6000)) @(posedge clk);
            #2 rst = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2 rst = 1'b0;
        end
        repeat (13000) @(posedge clk);
        chk("a_first_frame_seen_after_reset", int'(a_seen), 1);
        @(posedge clk);
        running = 1'b0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_game_timing.md
# vga_game_timing

Raster timing source for the Pac-Man display path. From one pixel clock it generates physical VGA sync and the upscaled game-space strobes and coordinates: `sx`, `sy`, `game_pix_stb`, `frame_stb` and `display_enabled`. The 224x288 game field is centred in the physical frame at an integer scale. `pacman_game` and any later game-side renderer consume these signals.

## Interface
- `H_VISIBLE`, 800: physical visible columns
- `H_FRONT`, 40 / `H_SYNC`, 128 / `H_BACK`, 88: horizontal porch and sync lengths (H_TOTAL 1056)
- `V_VISIBLE`, 600: physical visible lines
- `V_FRONT`, 1 / `V_SYNC`, 4 / `V_BACK`, 23: vertical porch and sync lengths (V_TOTAL 628)
- `SYNC_POL`, 1: active level of hsync/vsync
- `SCALE`, 2: physical pixels per game pixel, on both axes
- `GAME_W`, 224 / `GAME_H`, 288: game field size, taken from `params::pacman`
- `clk`  in  1  pixel clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `sx`  out  $clog2(GAME_W)  game column
- `sy`  out  $clog2(GAME_H)  game row
- `game_pix_stb`  out  1  one-cycle strobe per virtual game pixel
- `frame_stb`  out  1  one-cycle strobe at game pixel (0,0)
- `display_enabled`  out  1  current physical pixel lies inside the game window

## Operation
- **Physical counters**
  - `hc` runs 0..H_TOTAL-1 and wraps.
  - `vc` increments when `hc` wraps, and itself wraps at V_TOTAL-1.
- **Game window**
  - `H_OFF` = (H_VISIBLE - GAME_W·SCALE)/2 = 176.
  - `V_OFF` = (V_VISIBLE - GAME_H·SCALE)/2 = 12.
  - Inside the window: H_OFF ≤ hc < H_OFF+GAME_W·SCALE, and V_OFF ≤ vc < V_OFF+GAME_H·SCALE.
- **Sub-counters**
  - `hsub` counts 0..SCALE-1 inside the window.
  - `sx` increments when `hsub` wraps.
  - `hsub` and `sx` clear at the window's left edge.
  - `vsub` and `sy` behave the same way per line, clearing at the top edge each frame.
- **Sync:** hsync = SYNC_POL for H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC; vsync uses the same rule with `vc` and the V parameters.
- **Window outputs**
  - `display_enabled` = inside the window.
  - `sx` and `sy` read 0 whenever `display_enabled` = 0.
- **Strobes**
  - `game_pix_stb` = inside the window && hsub==0 && vsub==0.
  - `frame_stb` = `game_pix_stb` && sx==0 && sy==0.
- Every game pixel (x,y) gets exactly one `game_pix_stb` per frame, and `frame_stb` fires exactly once per frame.
- Widths: `hc` uses $clog2(H_TOTAL) bits and `vc` uses $clog2(V_TOTAL) bits. All comparisons are unsigned, with no overflow beyond the wrap points.

## Timing
- **Reset values:** hc=vc=hsub=vsub=0; hsync=vsync=!SYNC_POL; sx=sy=0; game_pix_stb=frame_stb=display_enabled=0.
- **First count:** the first cycle after `rst` deasserts has hc=0, vc=0.
- **Output latency:** all outputs are registered. Outputs for counter state n appear one cycle later, so all outputs stay mutually aligned.
- **Frame length:** 663168 cycles, strobe to strobe.
- **Reset mid-frame:** outputs and counters return to reset values immediately. Counting restarts at (0,0) on release, and no partial strobes are emitted.

## Configuration
- Macro: `GAME_PIX_STB_ALL_LINES_EN`.
- Defined: `game_pix_stb` = inside the window && hsub==0, on every physical line. It fires SCALE times per game pixel per frame, and `frame_stb` is unchanged (still vsub==0 only).
- Undefined: single strobe per game pixel per frame, as described in Operation.

## Structure
- Package `params::vga`: H/V timing constants and SYNC_POL.
- `GAME_W` and `GAME_H` stay in `params::pacman` (H_VISIBLE_AREA, V_VISIBLE_AREA).
- Sub-module `game_axis_counter`:
  - Instantiated once per axis.
  - Parameters: total, offset, scale and game size.
  - Inputs: an advance enable and a wrap strobe from the lower axis.
  - Outputs: physical count, in-window flag, sub-count and game coordinate.

## Test plan
- Reset, then release:
  - First `frame_stb`=1 with sx=0, sy=0, display_enabled=1 in cycle 12·1056+176+1 = 12849.
  - Next `frame_stb` exactly 663168 cycles later.
- Line 12:
  - display_enabled is high for exactly 448 cycles.
  - 224 `game_pix_stb` pulses, 2 cycles apart.
  - sx goes 0..223; the last pulse shows sx=223.
  - display_enabled drops when hc=624.
- Full frame:
  - hsync asserted for hc 840..967.
  - vsync asserted for vc 601..604.
  - Polarity flips when SYNC_POL=0.
- Count over one frame: 64512 `game_pix_stb` pulses and 1 `frame_stb`; sy reaches 287 and none above. With `GAME_PIX_STB_ALL_LINES_EN` defined, 129024 pulses.
- Assert `rst` at hc=300, vc=200 for 3 cycles:
  - All outputs reach reset values asynchronously.
  - After release, the timing equals a fresh reset; first `frame_stb` again 12849 cycles later.
- SCALE=1 with V_OFF recomputed: `game_pix_stb` equals `display_enabled` on every cycle, and sx increments each cycle.
